// File: rtl/bioee_dac_writer_pkg.sv
// Shared FSM encoding and default constants for the BioEE DAC writer slice.
package bioee_dac_writer_pkg;

    localparam int unsigned WORD_W          = 16;
    localparam int unsigned DEF_CLKDIV      = 4;
    localparam int unsigned DEF_DEPTH       = 16;
    localparam int unsigned DEF_BLOCK_WORDS = 8;
    localparam int unsigned DEF_GAP_CYCLES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } dac_state_e;

endpackage

// File: rtl/bioee_dac_writer_if.sv
// Block-throttled pipe carrying DAC words from the host into the writer.
interface bioee_dac_writer_if;
    import bioee_dac_writer_pkg::*;

    logic              btpipeI_dac_write;
    logic              btpipeI_dac_block;
    logic [WORD_W-1:0] btpipeI_dac_data;
    logic              btpipeI_dac_ready;

    modport master (
        output btpipeI_dac_write,
        output btpipeI_dac_block,
        output btpipeI_dac_data,
        input  btpipeI_dac_ready
    );

    modport slave (
        input  btpipeI_dac_write,
        input  btpipeI_dac_block,
        input  btpipeI_dac_data,
        output btpipeI_dac_ready
    );

endinterface

// File: rtl/bioee_dac_writer_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO succeeds when a pop happens in the same cycle.
module bioee_sync_fifo
    import bioee_dac_writer_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = WORD_W,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             push_ok,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/bioee_dac_writer.sv
// Buffers host words and shifts each one out as a 16-bit SPI-style DAC frame, MSB first.
module bioee_dac_writer
    import bioee_dac_writer_pkg::*;
#(
    parameter int unsigned CLKDIV      = DEF_CLKDIV,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                 ti_clk,
    input  logic                 resetin,
    input  logic                 enable,
    bioee_dac_writer_if.slave    pipe,
    output logic                 dac_sclk,
    output logic                 dac_sync_n,
    output logic                 dac_din,
    output logic                 busy,
    output logic                 overflow,
    output logic [WORD_W-1:0]    words_sent
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned DIV_W = 8;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    dac_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        edge_q, edge_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [14:0]       shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic              sync_n_q, sync_n_d;
    logic              din_q, din_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              ready_q, ready_d;
    logic [WORD_W-1:0] sent_q, sent_d;

    logic [WORD_W-1:0] fifo_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_push_ok;

    bioee_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (ti_clk),
        .rst       (resetin),
        .push      (pipe.btpipeI_dac_write),
        .push_data (pipe.btpipeI_dac_data),
        .pop       (state_q == ST_LOAD),
        .pop_data  (fifo_data),
        .push_ok   (fifo_push_ok),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        edge_d   = edge_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        sync_n_d = sync_n_q;
        din_d    = din_q;
        sent_d   = sent_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d  = fifo_data[14:0];
                din_d    = fifo_data[15];
                sclk_d   = 1'b1;
                sync_n_d = 1'b0;
                div_d    = '0;
                edge_d   = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q == DIV_W'(CLKDIV - 1)) begin
                    div_d = '0;
                    // The 32nd half-period ends the frame instead of raising sclk again.
                    if (edge_q == 5'd31) begin
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        din_d    = 1'b0;
                        sent_d   = sent_q + 1'b1;
                        gap_d    = '0;
                        state_d  = ST_GAP;
                    end else begin
                        edge_d = edge_q + 1'b1;
                        sclk_d = !sclk_q;
                        if (!sclk_q) begin
                            din_d   = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d != ST_IDLE);
        ovf_d   = ovf_q | (pipe.btpipeI_dac_write & ~fifo_push_ok);
        ready_d = ((CNT_W'(DEPTH) - fifo_count) >= CNT_W'(BLOCK_WORDS));
    end

    always_ff @(posedge ti_clk or posedge resetin) begin
        if (resetin) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            edge_q   <= '0;
            gap_q    <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            gap_q    <= gap_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            sync_n_q <= sync_n_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            sent_q   <= sent_d;
        end
    end

    assign dac_sclk               = sclk_q;
    assign dac_sync_n             = sync_n_q;
    assign dac_din                = din_q;
    assign busy                   = busy_q;
    assign overflow               = ovf_q;
    assign words_sent             = sent_q;
    assign pipe.btpipeI_dac_ready = ready_q;

endmodule

// File: tb/tb_bioee_dac_writer.sv
// Scoreboard bench: expected frame words are queued at write time and checked as each DAC frame completes.
module tb_bioee_dac_writer;
    import bioee_dac_writer_pkg::*;

    localparam int unsigned CLKDIV      = 4;
    localparam int unsigned DEPTH       = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned GAP_CYCLES  = 4;

    logic        ti_clk  = 1'b0;
    logic        resetin = 1'b1;
    logic        enable  = 1'b0;
    logic        dac_sclk, dac_sync_n, dac_din, busy, overflow;
    logic [15:0] words_sent;

    bioee_dac_writer_if pipe ();

    always #5 ti_clk = ~ti_clk;

    bioee_dac_writer #(
        .CLKDIV      (CLKDIV),
        .DEPTH       (DEPTH),
        .BLOCK_WORDS (BLOCK_WORDS),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .ti_clk     (ti_clk),
        .resetin    (resetin),
        .enable     (enable),
        .pipe       (pipe.slave),
        .dac_sclk   (dac_sclk),
        .dac_sync_n (dac_sync_n),
        .dac_din    (dac_din),
        .busy       (busy),
        .overflow   (overflow),
        .words_sent (words_sent)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int unsigned exp_ws = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame monitor: reassembles each frame from falling-edge samples.
    logic [15:0] m_word;
    int unsigned m_low, m_fall, m_high;
    logic        m_prev_sclk, m_prev_sync, m_in_frame;
    logic [15:0] m_exp;

    initial begin
        m_word = '0; m_low = 0; m_fall = 0; m_high = GAP_CYCLES;
        m_prev_sclk = 1'b1; m_prev_sync = 1'b1; m_in_frame = 1'b0;
        forever begin
            @(negedge ti_clk);
            if (resetin) begin
                m_in_frame = 1'b0; m_high = GAP_CYCLES; exp_ws = 0;
                m_prev_sclk = 1'b1; m_prev_sync = 1'b1;
            end else begin
                if (!dac_sync_n) begin
                    if (m_prev_sync) begin
                        chk("gap_min", 32'(m_high >= GAP_CYCLES), 1);
                        m_in_frame = 1'b1; m_low = 0; m_fall = 0; m_word = '0;
                    end
                    m_low++;
                    if (m_prev_sclk && !dac_sclk) begin
                        m_word = {m_word[14:0], dac_din};
                        m_fall++;
                    end
                end else begin
                    if (!m_prev_sync && m_in_frame) begin
                        m_in_frame = 1'b0;
                        m_high = 0;
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_frame actual=%0h expected=none", m_word);
                        end else begin
                            m_exp = exp_q.pop_front();
                            exp_ws++;
                            chk("frame_word", m_word, m_exp);
                            chk("sync_low_cycles", m_low, 32 * CLKDIV);
                            chk("falling_edges", m_fall, 16);
                            chk("words_sent", words_sent, exp_ws);
                            chk("end_sclk", dac_sclk, 1);
                            chk("end_din", dac_din, 0);
                        end
                    end
                    m_high++;
                end
                m_prev_sclk = dac_sclk;
                m_prev_sync = dac_sync_n;
            end
        end
    end

    task automatic do_reset();
        @(negedge ti_clk);
        resetin = 1'b1;
        enable  = 1'b0;
        pipe.btpipeI_dac_write = 1'b0;
        pipe.btpipeI_dac_block = 1'b0;
        pipe.btpipeI_dac_data  = '0;
        exp_q.delete();
        #1;
        chk("rst_sclk", dac_sclk, 1);
        chk("rst_sync_n", dac_sync_n, 1);
        chk("rst_din", dac_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_words_sent", words_sent, 0);
        chk("rst_ready", pipe.btpipeI_dac_ready, 0);
        repeat (2) @(negedge ti_clk);
        resetin = 1'b0;
        @(negedge ti_clk);
        chk("ready_after_reset", pipe.btpipeI_dac_ready, 1);
    endtask

    task automatic write_word(input logic [15:0] w, input bit expect_sent);
        @(negedge ti_clk);
        pipe.btpipeI_dac_write = 1'b1;
        pipe.btpipeI_dac_data  = w;
        if (expect_sent) exp_q.push_back(w);
        @(negedge ti_clk);
        pipe.btpipeI_dac_write = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned max_cycles);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
            @(negedge ti_clk);
            n++;
        end
        chk("drain_in_time", 32'(n < max_cycles), 1);
    endtask

    task automatic wait_sync_low(input int unsigned max_cycles);
        int unsigned n = 0;
        while (dac_sync_n && n < max_cycles) begin
            @(negedge ti_clk);
            n++;
        end
        chk("frame_started", 32'(n < max_cycles), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pipe.btpipeI_dac_write = 1'b0;
        pipe.btpipeI_dac_block = 1'b0;
        pipe.btpipeI_dac_data  = '0;

        // Single frame, 0xA5C3
        do_reset();
        enable = 1'b1;
        write_word(16'hA5C3, 1'b1);
        wait_drain(1000);
        chk("single_words_sent", words_sent, 1);

        // Eight words held off by enable, then released
        do_reset();
        for (int i = 0; i < 8; i++) write_word(16'h3100 + 16'(i * 16'h0111), 1'b1);
        repeat (40) @(negedge ti_clk);
        chk("disabled_busy", busy, 0);
        chk("disabled_sync_n", dac_sync_n, 1);
        chk("disabled_words_sent", words_sent, 0);
        enable = 1'b1;
        wait_drain(8 * 200);
        chk("eight_words_sent", words_sent, 8);
        chk("eight_fifo_empty", dut.fifo_count, 0);

        // 17 back-to-back words into a 16-deep FIFO
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            @(negedge ti_clk);
            if (i == 10) chk("ready_count8", pipe.btpipeI_dac_ready, 1);
            if (i == 11) chk("ready_count9", pipe.btpipeI_dac_ready, 0);
            if (i == 17) chk("overflow_before_17th", overflow, 0);
            pipe.btpipeI_dac_write = 1'b1;
            pipe.btpipeI_dac_data  = 16'hC000 + 16'(i);
            if (i <= 16) exp_q.push_back(16'hC000 + 16'(i));
        end
        @(negedge ti_clk);
        pipe.btpipeI_dac_write = 1'b0;
        chk("overflow_on_17th", overflow, 1);
        repeat (20) @(negedge ti_clk);
        chk("overflow_sticky", overflow, 1);
        enable = 1'b1;
        wait_drain(17 * 200);
        chk("overflow_words_sent", words_sent, 16);
        chk("overflow_after_drain", overflow, 1);

        // Reset in the middle of bit 7
        do_reset();
        enable = 1'b1;
        write_word(16'h5A3C, 1'b1);
        wait_sync_low(100);
        repeat (66) @(negedge ti_clk);
        resetin = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_sync_n", dac_sync_n, 1);
        chk("abort_sclk", dac_sclk, 1);
        chk("abort_busy", busy, 0);
        chk("abort_words_sent", words_sent, 0);
        repeat (2) @(negedge ti_clk);
        resetin = 1'b0;
        repeat (300) @(negedge ti_clk);
        chk("abort_no_frames", words_sent, 0);
        chk("abort_idle_busy", busy, 0);

        // Full FIFO, write coincident with the LOAD pop
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            @(negedge ti_clk);
            pipe.btpipeI_dac_write = 1'b1;
            pipe.btpipeI_dac_data  = 16'h7700 + 16'(i);
            exp_q.push_back(16'h7700 + 16'(i));
        end
        @(negedge ti_clk);
        pipe.btpipeI_dac_write = 1'b0;
        enable = 1'b1;
        chk("full_count", dut.fifo_count, 16);
        @(negedge ti_clk);
        chk("load_busy", busy, 1);
        pipe.btpipeI_dac_write = 1'b1;
        pipe.btpipeI_dac_data  = 16'h77FF;
        exp_q.push_back(16'h77FF);
        @(negedge ti_clk);
        pipe.btpipeI_dac_write = 1'b0;
        chk("coincident_overflow", overflow, 0);
        chk("coincident_count", dut.fifo_count, 16);
        wait_drain(17 * 200);
        chk("coincident_words_sent", words_sent, 17);
        chk("coincident_overflow_end", overflow, 0);

        // Enable dropped during bit 3
        do_reset();
        enable = 1'b1;
        write_word(16'h9E61, 1'b1);
        write_word(16'h1234, 1'b0);
        wait_sync_low(100);
        repeat (98) @(negedge ti_clk);
        enable = 1'b0;
        wait_drain(500);
        repeat (50) @(negedge ti_clk);
        chk("disable_words_sent", words_sent, 1);
        chk("disable_busy", busy, 0);
        chk("disable_fifo_left", dut.fifo_count, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bioee_dac_writer.md
BIOEE_DAC_WRITER -- requirements
Module: BioEE_dac_writer

Interface
REQ-001 Parameter CLKDIV, default 4: ti_clk cycles per dac_sclk half-period (legal range 2..255).
REQ-002 Parameter DEPTH, default 16: FIFO depth in 16-bit words (power of 2, ≥ 2*BLOCK_WORDS).
REQ-003 Parameter BLOCK_WORDS, default 8: pipe block size in words, used for ready.
REQ-004 Parameter GAP_CYCLES, default 4: minimum ti_clk cycles dac_sync_n stays high between frames.
REQ-005 ti_clk  input  1  sole clock, all logic on rising edge.
REQ-006 resetin  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  permits starting new frames.
REQ-008 btpipeI_dac_write  input  1  data word valid this cycle.
REQ-009 btpipeI_dac_block  input  1  block strobe, informational only, ignored.
REQ-010 btpipeI_dac_data  input  16  DAC word.
REQ-011 btpipeI_dac_ready  output  1  room for a full block.
REQ-012 dac_sclk  output  1  serial clock, idle high.
REQ-013 dac_sync_n  output  1  frame select, active low.
REQ-014 dac_din  output  1  serial data, MSB first.
REQ-015 busy  output  1  frame or gap in progress.
REQ-016 overflow  output  1  sticky, word dropped because FIFO full.
REQ-017 words_sent  output  16  completed-frame count.

Function
REQ-018 A write is accepted when btpipeI_dac_write=1 and count<DEPTH, or count=DEPTH with a pop in the same cycle; otherwise the word is dropped and overflow sets.
REQ-019 overflow shall clear only on resetin.
REQ-020 btpipeI_dac_ready shall be registered: high the cycle after (DEPTH-count) ≥ BLOCK_WORDS.
REQ-021 FSM states: IDLE, LOAD, SHIFT, GAP.
REQ-022 IDLE→LOAD when enable=1 and FIFO non-empty; LOAD pops one word into a 16-bit shift register in one cycle.
REQ-023 On entry to SHIFT: dac_sync_n=0, dac_din=bit15, dac_sclk=1.
REQ-024 In SHIFT, dac_sclk toggles every CLKDIV cycles; falling edge = DAC sample point; on each rising edge dac_din advances to next lower bit.
REQ-025 After the 16th falling edge plus CLKDIV cycles: dac_sclk=1 and dac_sync_n=1 in the same cycle, words_sent increments (wraps 0xFFFF→0), state→GAP.
REQ-026 dac_sync_n low time shall be exactly 32*CLKDIV cycles per frame.
REQ-027 GAP lasts GAP_CYCLES cycles with dac_din=0, then →IDLE; back-to-back words therefore have frame period 32*CLKDIV+GAP_CYCLES+2 cycles.
REQ-028 enable deasserted mid-frame: current frame and gap complete; no new LOAD.
REQ-029 busy=1 in LOAD, SHIFT, GAP; 0 in IDLE.
REQ-030 FIFO empty in IDLE: outputs hold idle values, no underflow condition exists.

Reset
REQ-031 resetin=1 immediately forces: dac_sclk=1, dac_sync_n=1, dac_din=0, busy=0, overflow=0, words_sent=0, btpipeI_dac_ready=0, FIFO empty, state IDLE.
REQ-032 Reset mid-frame aborts the frame without completing it; the word is discarded and not counted.
REQ-033 First cycle after reset release: btpipeI_dac_ready rises (FIFO empty).

Structure
REQ-034 FSM state encoding and default parameter constants shall live in the shared BioEE package.
REQ-035 The FIFO shall be a separate sub-module BioEE_sync_fifo (synchronous, count output, pop/push same-cycle safe).

Verification
REQ-036 Reset, write 0xA5C3 with enable=1, CLKDIV=4 -> dac_din bits 1010010111000011 sampled at 16 falling edges, dac_sync_n low exactly 128 cycles, words_sent=1.
REQ-037 Write 8 words with enable=0, then enable=1 -> no activity while disabled; 8 frames, each separated by dac_sync_n high ≥ GAP_CYCLES, words_sent=8, FIFO empty.
REQ-038 Write 17 words back-to-back with enable=0, DEPTH=16 -> 17th dropped, overflow=1 and sticky, ready low after 9th word.
REQ-039 Assert resetin at bit 7 of a frame -> same cycle dac_sync_n=1, dac_sclk=1; words_sent=0; no further frames.
REQ-040 FIFO at count=16 during active transmission, write coincident with LOAD pop -> word accepted, overflow stays 0.
REQ-041 Drop enable during bit 3 -> frame completes all 16 bits, no subsequent frame starts.
